// File: rtl/alu_pkg.sv
// Shared ALU operation codes for the decoder, the single-cycle ALU and the muldiv unit.
// Codes with bit 3 set belong to the RV32M multi-cycle unit.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLL    = 4'b0101,
        ALU_SRL    = 4'b0110,
        ALU_SRA    = 4'b0111,
        ALU_MUL    = 4'b1000,
        ALU_MULH   = 4'b1001,
        ALU_MULHSU = 4'b1010,
        ALU_MULHU  = 4'b1011,
        ALU_DIV    = 4'b1100,
        ALU_DIVU   = 4'b1101,
        ALU_REM    = 4'b1110,
        ALU_REMU   = 4'b1111
    } alu_op_e;

endpackage

// File: rtl/div_core.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on operand magnitudes,
// sign fixup applied combinationally to the final quotient/remainder registers.
module div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            last,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int CW = $clog2(XLEN);

    logic            busy_r;
    logic [CW-1:0]   cnt_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] dvs_r;
    logic            q_neg_r;
    logic            r_neg_r;
    logic [XLEN-1:0] mag_a_s;
    logic [XLEN-1:0] mag_b_s;
    logic [XLEN:0]   shifted_s;
    logic [XLEN:0]   diff_s;

    // operand magnitudes and one restoring trial subtraction
    always_comb begin
        mag_a_s   = (is_signed && dividend[XLEN-1]) ? ({XLEN{1'b0}} - dividend) : dividend;
        mag_b_s   = (is_signed && divisor[XLEN-1])  ? ({XLEN{1'b0}} - divisor)  : divisor;
        shifted_s = {rem_r, quo_r[XLEN-1]};
        diff_s    = shifted_s - {1'b0, dvs_r};
    end

    // iteration state: load on start, shift one bit per busy cycle, stop after XLEN bits
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            quo_r   <= {XLEN{1'b0}};
            rem_r   <= {XLEN{1'b0}};
            dvs_r   <= {XLEN{1'b0}};
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (abort) begin
            busy_r <= 1'b0;
        end else if (start) begin
            busy_r  <= 1'b1;
            cnt_r   <= {CW{1'b0}};
            quo_r   <= mag_a_s;
            rem_r   <= {XLEN{1'b0}};
            dvs_r   <= mag_b_s;
            q_neg_r <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            r_neg_r <= is_signed && dividend[XLEN-1];
        end else if (busy_r) begin
            // a clear top bit means the trial subtraction did not go negative
            if (!diff_s[XLEN]) begin
                rem_r <= diff_s[XLEN-1:0];
                quo_r <= {quo_r[XLEN-2:0], 1'b1};
            end else begin
                rem_r <= shifted_s[XLEN-1:0];
                quo_r <= {quo_r[XLEN-2:0], 1'b0};
            end
            cnt_r <= cnt_r + CW'(1);
            if (last) begin
                busy_r <= 1'b0;
            end
        end
    end

    assign last      = busy_r && (cnt_r == CW'(XLEN - 1));
    assign quotient  = q_neg_r ? ({XLEN{1'b0}} - quo_r) : quo_r;
    assign remainder = r_neg_r ? ({XLEN{1'b0}} - rem_r) : rem_r;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit: multiply in two cycles, divide via div_core, divide special cases
// resolved at accept; one-cycle out_valid pulse per completed operation.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);
    import alu_pkg::*;

    localparam int PW = 2 * XLEN;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DSPEC = 3'd2,
        S_DIV   = 3'd3,
        S_FIX   = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    state_e            state_r;
    state_e            state_s;
    alu_op_e           op_r;
    logic [PW-1:0]     prod_r;
    logic [XLEN-1:0]   spec_r;
    logic [XLEN-1:0]   result_r;
    logic [XLEN-1:0]   result_s;
    logic [XLEN-1:0]   spec_s;
    logic [XLEN-1:0]   div_quo_s;
    logic [XLEN-1:0]   div_rem_s;
    logic              accept_s;
    logic              is_div_s;
    logic              div_signed_s;
    logic              div_zero_s;
    logic              div_ovf_s;
    logic              div_spec_s;
    logic              div_start_s;
    logic              div_last_s;
    logic signed [XLEN:0] mul_a_s;
    logic signed [XLEN:0] mul_b_s;
    logic signed [PW-1:0] prod_s;

    // request decode, divide special cases and the extended-operand product
    always_comb begin
        accept_s     = in_valid && (state_r == S_IDLE) && alu_ctrl[3] && !flush;
        is_div_s     = alu_ctrl[2];
        div_signed_s = !alu_ctrl[0];
        div_zero_s   = (op_b == {XLEN{1'b0}});
        div_ovf_s    = div_signed_s && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == {XLEN{1'b1}});
        div_spec_s   = div_zero_s || div_ovf_s;
        div_start_s  = accept_s && is_div_s && !div_spec_s;
        if (div_zero_s) begin
            spec_s = alu_ctrl[1] ? op_a : {XLEN{1'b1}};
        end else if (div_ovf_s) begin
            spec_s = alu_ctrl[1] ? {XLEN{1'b0}} : op_a;
        end else begin
            spec_s = {XLEN{1'b0}};
        end
        // op_a is signed for MULH/MULHSU, op_b only for MULH
        mul_a_s = {((alu_ctrl[1:0] == 2'b01) || (alu_ctrl[1:0] == 2'b10)) ? op_a[XLEN-1] : 1'b0, op_a};
        mul_b_s = {(alu_ctrl[1:0] == 2'b01) ? op_b[XLEN-1] : 1'b0, op_b};
        prod_s  = PW'(mul_a_s) * PW'(mul_b_s);
    end

    // next state and the value captured into result on entry to DONE
    always_comb begin
        state_s  = state_r;
        result_s = result_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (!is_div_s) begin
                        state_s = S_MUL;
                    end else if (div_spec_s) begin
                        state_s = S_DSPEC;
                    end else begin
                        state_s = S_DIV;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_s = S_IDLE;
                end else begin
                    state_s  = S_DONE;
                    result_s = (op_r == ALU_MUL) ? prod_r[XLEN-1:0] : prod_r[PW-1:XLEN];
                end
            end
            S_DSPEC: begin
                if (flush) begin
                    state_s = S_IDLE;
                end else begin
                    state_s  = S_DONE;
                    result_s = spec_r;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_s = S_IDLE;
                end else if (div_last_s) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_DIV;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_s = S_IDLE;
                end else begin
                    state_s  = S_DONE;
                    result_s = ((op_r == ALU_REM) || (op_r == ALU_REMU)) ? div_rem_s : div_quo_s;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // state, latched operation and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            op_r     <= ALU_ADD;
            prod_r   <= {PW{1'b0}};
            spec_r   <= {XLEN{1'b0}};
            result_r <= {XLEN{1'b0}};
        end else begin
            state_r  <= state_s;
            result_r <= result_s;
            if (accept_s) begin
                op_r   <= alu_op_e'(alu_ctrl);
                prod_r <= prod_s;
                spec_r <= spec_s;
            end
        end
    end

    div_core #(.XLEN(XLEN)) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .abort     (flush),
        .is_signed (div_signed_s),
        .dividend  (op_a),
        .divisor   (op_b),
        .last      (div_last_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    assign in_ready  = (state_r == S_IDLE);
    assign out_valid = (state_r == S_DONE);
    assign result    = result_r;

endmodule
